// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_mem_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_start;
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  i_byte_last;
    logic                  o_byte_ready;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_overflow;
    logic [ADDR_WIDTH-1:0] o_word_count;

    // Firmware source side: drives the byte stream, observes the loader.
    modport master (
        output i_start, i_byte, i_byte_valid, i_byte_last,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        input  o_busy, o_done, o_overflow, o_word_count
    );

    // Loader side.
    modport slave (
        input  i_start, i_byte, i_byte_valid, i_byte_last,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        output o_busy, o_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a big-endian firmware byte stream into 32-bit words and writes them
// to instruction memory, flagging completion or overflow of the memory.
module instr_mem_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ROM_BLOCKS_NUM = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    instr_mem_loader_if.slave  bus
);
    localparam int unsigned CNT_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr,       addr_nx;
    logic [CNT_WIDTH-1:0]  byte_cnt,   byte_cnt_nx;
    logic [DATA_WIDTH-1:0] asm_word,   asm_word_nx;
    logic                  last_seen,  last_seen_nx;
    logic [ADDR_WIDTH-1:0] word_count, word_count_nx;
    logic                  done,       done_nx;
    logic                  overflow,   overflow_nx;
    logic                  wr_en,      wr_en_nx;
    logic [ADDR_WIDTH-1:0] wr_addr,    wr_addr_nx;
    logic [DATA_WIDTH-1:0] wr_data,    wr_data_nx;
    logic                  byte_ready, byte_ready_nx;
    logic                  busy,       busy_nx;
    logic                  accept;
    logic                  addr_at_end;

    assign accept      = (state == COLLECT) && bus.i_byte_valid;
    assign addr_at_end = (addr == ADDR_WIDTH'(ROM_BLOCKS_NUM - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_nx      = state;
        addr_nx       = addr;
        byte_cnt_nx   = byte_cnt;
        asm_word_nx   = asm_word;
        last_seen_nx  = last_seen;
        word_count_nx = word_count;
        done_nx       = done;
        overflow_nx   = overflow;
        wr_addr_nx    = wr_addr;
        wr_data_nx    = wr_data;

        case (state)
            IDLE, DONE, ERR: begin
                if (bus.i_start) begin
                    state_nx      = COLLECT;
                    addr_nx       = '0;
                    byte_cnt_nx   = '0;
                    asm_word_nx   = '0;
                    last_seen_nx  = 1'b0;
                    word_count_nx = '0;
                    done_nx       = 1'b0;
                    overflow_nx   = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    // Lanes not yet filled stay zero because the word was cleared.
                    case (byte_cnt)
                        2'd0:    asm_word_nx[31:24] = bus.i_byte;
                        2'd1:    asm_word_nx[23:16] = bus.i_byte;
                        2'd2:    asm_word_nx[15:8]  = bus.i_byte;
                        default: asm_word_nx[7:0]   = bus.i_byte;
                    endcase
                    byte_cnt_nx  = byte_cnt + CNT_WIDTH'(1);
                    last_seen_nx = bus.i_byte_last;
                    if (bus.i_byte_last || (byte_cnt == 2'd3)) begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_nx = word_count + ADDR_WIDTH'(1);
                byte_cnt_nx   = '0;
                asm_word_nx   = '0;
                if (last_seen) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else if (addr_at_end) begin
                    state_nx    = ERR;
                    overflow_nx = 1'b1;
                end else begin
                    state_nx = COLLECT;
                    addr_nx  = addr + ADDR_WIDTH'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        wr_en_nx      = (state_nx == WRITE);
        byte_ready_nx = (state_nx == COLLECT);
        busy_nx       = (state_nx == COLLECT) || (state_nx == WRITE);
        if (state_nx == WRITE) begin
            wr_addr_nx = addr_nx;
            wr_data_nx = asm_word_nx;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr       <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            last_seen  <= 1'b0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            addr       <= addr_nx;
            byte_cnt   <= byte_cnt_nx;
            asm_word   <= asm_word_nx;
            last_seen  <= last_seen_nx;
            word_count <= word_count_nx;
            done       <= done_nx;
            overflow   <= overflow_nx;
            wr_en      <= wr_en_nx;
            wr_addr    <= wr_addr_nx;
            wr_data    <= wr_data_nx;
            byte_ready <= byte_ready_nx;
            busy       <= busy_nx;
        end
    end

    assign bus.o_byte_ready = byte_ready;
    assign bus.o_wr_en      = wr_en;
    assign bus.o_wr_addr    = wr_addr;
    assign bus.o_wr_data    = wr_data;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;
    assign bus.o_overflow   = overflow;
    assign bus.o_word_count = word_count;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader with a word-level reference model.
module tb_instr_mem_loader;
    localparam int unsigned ROM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    instr_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    instr_mem_loader #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .ROM_BLOCKS_NUM(ROM)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stim_q[$];
    bit          stim_last;
    bit          noisy;
    logic [63:0] wr_q[$];

    // Compare one observed value against the expected one.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record every memory write and check it stays inside the memory.
    always @(negedge clk) begin
        if (bus.o_wr_en) begin
            wr_q.push_back({bus.o_wr_addr, bus.o_wr_data});
            chk("wr_addr_bound", 64'(bus.o_wr_addr < ROM), 64'd1);
        end
    end

    // Start a session, stream stim_q, then compare against the word model.
    task automatic run_session();
        int          n;
        int          idx;
        int          budget;
        int          nw;
        int          exp_acc;
        int          total_w;
        bit          exp_ovf;
        bit          acc;
        logic [31:0] w;
        n = stim_q.size();
        total_w = stim_last ? (n + 3) / 4 : n / 4;
        exp_ovf = !stim_last || (total_w > int'(ROM));
        nw      = exp_ovf ? int'(ROM) : total_w;
        exp_acc = exp_ovf ? 4 * int'(ROM) : n;

        @(negedge clk);
        wr_q.delete();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("start_done_clr", 64'(bus.o_done), 64'd0);
        chk("start_ovf_clr", 64'(bus.o_overflow), 64'd0);
        chk("start_wcount", 64'(bus.o_word_count), 64'd0);
        chk("start_busy", 64'(bus.o_busy), 64'd1);

        idx = 0;
        budget = 0;
        while (idx < n && budget < 2000) begin
            if (!bus.o_busy) break;
            bus.i_byte_valid = noisy ? 1'($urandom % 2) : 1'b1;
            bus.i_byte       = stim_q[idx];
            bus.i_byte_last  = stim_last && (idx == n - 1);
            bus.i_start      = noisy ? 1'($urandom % 3 == 0) : 1'b0;
            acc = bus.i_byte_valid && bus.o_byte_ready;
            @(negedge clk);
            if (acc) idx++;
            budget++;
        end
        bus.i_start = 1'b0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_last = 1'b0;

        budget = 0;
        while (bus.o_busy && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("session_end", 64'(bus.o_busy), 64'd0);

        // Leftover bytes must be refused once the session has ended.
        for (int k = 0; k < 4 && idx < n; k++) begin
            bus.i_byte_valid = 1'b1;
            bus.i_byte = stim_q[idx];
            chk("refuse_ready", 64'(bus.o_byte_ready), 64'd0);
            @(negedge clk);
        end
        bus.i_byte_valid = 1'b0;
        @(negedge clk);

        chk("accepted", 64'(idx), 64'(exp_acc));
        chk("n_writes", 64'(wr_q.size()), 64'(nw));
        for (int k = 0; k < nw && k < wr_q.size(); k++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                w = {w[23:0], (4 * k + b < n) ? stim_q[4 * k + b] : 8'h00};
            end
            chk("wr_addr", 64'(wr_q[k][63:32]), 64'(k));
            chk("wr_data", 64'(wr_q[k][31:0]), 64'(w));
        end
        chk("done", 64'(bus.o_done), 64'(!exp_ovf));
        chk("overflow", 64'(bus.o_overflow), 64'(exp_ovf));
        chk("word_count", 64'(bus.o_word_count), 64'(nw));
        chk("idle_ready", 64'(bus.o_byte_ready), 64'd0);
    endtask

    initial begin
        int len;
        int got2;
        bus.i_start = 1'b0;
        bus.i_byte = 8'h00;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_last = 1'b0;
        noisy = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.o_byte_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_wcount", 64'(bus.o_word_count), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Bytes offered while idle are dropped.
        bus.i_byte_valid = 1'b1;
        bus.i_byte = 8'hFF;
        repeat (3) @(negedge clk);
        chk("idle_drop_ready", 64'(bus.o_byte_ready), 64'd0);
        bus.i_byte_valid = 1'b0;

        // Basic two-word load.
        stim_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        stim_last = 1'b1;
        run_session();

        // Partial word, also restarting straight from DONE.
        stim_q = '{8'h12, 8'h34};
        run_session();

        // Overflow: 20 bytes, no last.
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(8'(i + 8'h40));
        stim_last = 1'b0;
        run_session();

        // Handshake gaps with spurious start during the session.
        noisy = 1'b1;
        stim_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        stim_last = 1'b1;
        run_session();

        // Exactly filling the memory with last on the final byte.
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
        run_session();

        // Reset after 2 bytes of a word.
        noisy = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        got2 = 0;
        for (int c = 0; c < 20 && got2 < 2; c++) begin
            bus.i_byte_valid = 1'b1;
            bus.i_byte = 8'hD0 + 8'(got2);
            if (bus.o_byte_ready) got2++;
            @(negedge clk);
        end
        bus.i_byte_valid = 1'b0;
        chk("mid_bytes", 64'(got2), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.o_byte_ready), 64'd0);
        chk("mid_rst_wr_en", 64'(bus.o_wr_en), 64'd0);
        chk("mid_rst_wr_addr", 64'(bus.o_wr_addr), 64'd0);
        chk("mid_rst_wr_data", 64'(bus.o_wr_data), 64'd0);
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("mid_rst_done", 64'(bus.o_done), 64'd0);
        chk("mid_rst_ovf", 64'(bus.o_overflow), 64'd0);
        chk("mid_rst_wcount", 64'(bus.o_word_count), 64'd0);
        wr_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_write", 64'(wr_q.size()), 64'd0);
        chk("post_rst_wait", 64'(bus.o_busy), 64'd0);
        stim_q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h55};
        stim_last = 1'b1;
        run_session();

        // Random sessions.
        for (int s = 0; s < 12; s++) begin
            noisy = 1'($urandom % 2);
            stim_last = ($urandom % 4) != 0;
            len = int'($urandom_range(1, 20));
            if (!stim_last && len < 16) len = 16 + int'($urandom % 5);
            stim_q.delete();
            for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
            run_session();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word).
- ADDR_WIDTH, 32, write-address width.
- ROM_BLOCKS_NUM, 256, number of instruction words in the target memory.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- i_clk  input  1  single clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle pulse that begins a load session.
- i_byte  input  8  firmware byte stream.
- i_byte_valid  input  1  i_byte holds a valid byte.
- i_byte_last  input  1  qualifies i_byte as the final byte of the image.
- o_byte_ready  output  1  loader accepts a byte this cycle.
- o_wr_en  output  1  one-cycle write strobe to instruction memory.
- o_wr_addr  output  ADDR_WIDTH  word index (not byte address) being written.
- o_wr_data  output  DATA_WIDTH  assembled instruction word.
- o_busy  output  1  session in progress.
- o_done  output  1  image loaded successfully; sticky.
- o_overflow  output  1  image exceeded ROM_BLOCKS_NUM words; sticky.
- o_word_count  output  ADDR_WIDTH  number of words written this session.

Function
REQ-003 A byte SHALL be accepted only on a cycle where i_byte_valid and o_byte_ready are both 1.
REQ-004 Bytes SHALL be packed big-endian: the 1st accepted byte goes to bits 31:24, the 2nd to 23:16, the 3rd to 15:8, and the 4th to 7:0.
REQ-005 The FSM SHALL have the states IDLE, COLLECT, WRITE, DONE and ERR.
REQ-006 IDLE: o_byte_ready=0. On i_start, the FSM SHALL go to COLLECT and clear the address, byte counter, assembly register, o_word_count, o_done and o_overflow.
REQ-007 COLLECT: o_byte_ready=1. After the 4th byte is accepted, or after a byte accepted with i_byte_last=1, the FSM SHALL go to WRITE on the next edge.
REQ-008 A last byte accepted before the 4th byte position SHALL cause the remaining lower byte lanes to be zero-filled.
REQ-009 WRITE SHALL last exactly one cycle, with o_wr_en=1, o_byte_ready=0, o_wr_addr equal to the current word index and o_wr_data equal to the assembled word.
- Latency: the strobe occurs in the cycle after the completing byte is accepted.
REQ-010 On leaving WRITE, o_word_count SHALL increment and the byte counter and assembly register SHALL clear. The next state SHALL be:
- DONE if the last flag was captured;
- otherwise ERR if o_wr_addr was ROM_BLOCKS_NUM-1;
- otherwise COLLECT with the address incremented by 1.
REQ-011 DONE SHALL set o_done=1, and o_done SHALL hold until the next i_start. ERR SHALL set o_overflow=1, and o_overflow SHALL hold until the next i_start. Both states SHALL return to IDLE behaviour, with o_byte_ready=0.
REQ-012 The FSM SHALL leave DONE or ERR only on i_start, which SHALL behave as in REQ-006.
REQ-013 i_start SHALL be ignored in COLLECT and WRITE.
REQ-014 o_busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-015 i_byte_valid SHALL be ignored outside COLLECT, and such bytes SHALL be dropped, not buffered.
REQ-016 o_wr_en SHALL never assert for an address of ROM_BLOCKS_NUM or above.
REQ-017 The address counter SHALL NOT wrap.

Reset
REQ-018 While i_rst_n=0, the FSM SHALL be IDLE and all of the following SHALL be 0, independent of i_clk: o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count, and the internal counters.
REQ-019 Reset asserted mid-session SHALL abort the session with no further o_wr_en.
- After release, the loader SHALL wait for a new i_start.

Verification
REQ-020 Basic load: i_start, then bytes 8C,01,00,04,AC,02,00,08 with last on the 8th byte. Required response:
- o_wr_en at addr 0 with data 32'h8C010004;
- o_wr_en at addr 1 with data 32'hAC020008;
- then o_done=1, o_word_count=2, o_busy=0.
REQ-021 Partial word: i_start, then bytes 12,34 with last on 34. Required response: a single write at addr 0 with data 32'h12340000, then o_done=1.
REQ-022 Overflow: with ROM_BLOCKS_NUM=4, stream 20 bytes with no last. Required response:
- writes at addrs 0..3;
- ERR after the addr-3 write, with o_overflow=1;
- the remaining 4 bytes see o_byte_ready=0, and no addr-4 write occurs.
REQ-023 Handshake gaps: toggle i_byte_valid randomly, and assert i_start and i_byte_valid during WRITE. Required response: data is identical to REQ-020, the session is not restarted, and no byte is lost or duplicated.
REQ-024 Reset mid-session: deassert i_rst_n after 2 bytes of a word. Required response:
- all outputs are 0 immediately;
- no o_wr_en occurs;
- a new session after release writes addr 0 with fresh data.
REQ-025 Restart after done: issue i_start while in DONE. Required response: o_done clears the next cycle, o_word_count=0, and addressing restarts at 0.
